systolic_drain: RTL and testbench

Output-side reader for the weight-stationary MAC array. It captures the accumulator values leaving the bottom row of an N-column array and removes the per-column skew, so column j's result, which arrives j cycles after column 0's, lines up with the rest of its row. Each aligned row is scaled and narrowed to OUT_WIDTH, buffered in a row FIFO, and presented to downstream logic over a valid/ready stream. It also gives the array controller back-pressure (`stall_o`) and a sticky overflow flag.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/row_fifo.sv | 82 ++++++++
 rtl/systolic_drain.sv | 122 ++++++++++++
 tb/tb_systolic_drain.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, row typedef and the narrowing helper.
// SYSTOLIC_DRAIN_SAT_EN selects saturating narrowing; default truncates.
package systolic_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 64;
  localparam int N_COLS     = 4;

  typedef logic [N_COLS-1:0][DATA_WIDTH-1:0] row_t;

  // Returns v narrowed to w bits, sign-extended back to 64.
  function automatic logic signed [63:0] sat_narrow(
    input logic signed [63:0] v,
    input int unsigned        w
  );
`ifdef SYSTOLIC_DRAIN_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo: single-clock row FIFO with a registered head row.
// Head register loads one cycle after a row lands; push-on-full-with-pop ok.
module row_fifo
  import systolic_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  parameter int AFULL = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_ready_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   rd_valid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   afull_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] raddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          afull_q, afull_d;
  logic          push, pop, load;

  // Pointer, count and head-register next state.
  always_comb begin
    pop      = valid_q & rd_ready_i;
    push     = wr_en_i & ((cnt_q != CW'(DEPTH)) | pop);
    load     = pop ? (cnt_q > CW'(1))
                   : (~valid_q & (cnt_q != '0));
    raddr    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    valid_d  = load | (valid_q & ~pop);
    data_d   = load ? mem[raddr] : data_q;
    afull_d  = cnt_d >= CW'(AFULL);
  end

  // Row storage; the head register supplies the reset value.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  // Control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      afull_q  <= afull_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign full_o     = cnt_q == CW'(DEPTH);
  assign empty_o    = cnt_q == '0;
  assign count_o    = cnt_q;
  assign afull_o    = afull_q;

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: deskews bottom-row accumulators, narrows, queues rows.
// Narrowing saturates when SYSTOLIC_DRAIN_SAT_EN is defined.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int ACC_WIDTH  = systolic_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH  = systolic_pkg::DATA_WIDTH,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N*ACC_WIDTH-1:0]        acc_i,
  input  logic                          row_valid_i,
  output logic                          stall_o,
  output logic [N*OUT_WIDTH-1:0]        out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  input  logic                          clr_ovf_i
);

  localparam int RW = N * OUT_WIDTH;

  logic [ACC_WIDTH-1:0] aligned [N];
  logic [RW-1:0]        row_cv;
  logic                 dv;
  logic                 fifo_full;
  logic                 fifo_empty_unused;
  logic                 drop;
  logic                 ovf_q, ovf_d;

  if (N > 1) begin : g_vdl
    logic [N-2:0] vdl_q, vdl_d;

    // Launch strobe travels alongside column 0.
    always_comb begin
      vdl_d = (vdl_q << 1) | (N-1)'(row_valid_i);
    end

    // Valid delay line.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) vdl_q <= '0;
      else       vdl_q <= vdl_d;
    end

    assign dv = vdl_q[N-2];
  end else begin : g_novdl
    assign dv = row_valid_i;
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    logic [ACC_WIDTH-1:0]        col_in;
    logic signed [ACC_WIDTH-1:0] sh;

    assign col_in = acc_i[j*ACC_WIDTH +: ACC_WIDTH];

    if (D == 0) begin : g_nd
      assign aligned[j] = col_in;
    end else begin : g_dl
      logic [ACC_WIDTH-1:0] dl_q [D];
      logic [ACC_WIDTH-1:0] dl_d [D];

      // Early columns wait for the last one.
      always_comb begin
        dl_d[0] = col_in;
        for (int k = 1; k < D; k++) dl_d[k] = dl_q[k-1];
      end

      // Column delay line.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < D; k++) dl_q[k] <= '0;
        end else begin
          dl_q <= dl_d;
        end
      end

      assign aligned[j] = dl_q[D-1];
    end

    assign sh = $signed(aligned[j]) >>> SHIFT;
    assign row_cv[j*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'(sat_narrow(64'(sh), OUT_WIDTH));
  end

  row_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH),
    .AFULL (FIFO_DEPTH - N)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (dv),
    .wr_data_i  (row_cv),
    .rd_ready_i (out_ready_i),
    .rd_data_o  (out_data_o),
    .rd_valid_o (out_valid_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty_unused),
    .count_o    (count_o),
    .afull_o    (stall_o)
  );

  // A drop sets the flag even when a clear arrives together.
  always_comb begin
    drop  = dv & fifo_full & ~(out_valid_o & out_ready_i);
    ovf_d = drop | (ovf_q & ~clr_ovf_i);
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed checks of deskew, back-pressure,
// overflow, conversion and reset.
module tb_systolic_drain;

  localparam int N     = 4;
  localparam int AW    = 64;
  localparam int OW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rstn;
  logic [N*AW-1:0] acc, c_acc;
  logic            row_valid, c_valid;
  logic            ready, c_ready;
  logic            clr_ovf, c_clr;
  logic            stall, c_stall;
  logic            ovalid, c_ovalid;
  logic            ovf, c_ovf;
  logic [N*OW-1:0] odata, c_odata;
  logic [CW-1:0]   count, c_count;

  int n_run;
  int n_fail;

  bit          hv  [N];
  logic [63:0] hb  [N];
  bit          chv [N];
  logic [63:0] chb [N];
  logic [63:0] e   [7];

  systolic_drain #(
    .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
    .SHIFT(0), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rstn(rstn), .acc_i(acc),
    .row_valid_i(row_valid), .stall_o(stall),
    .out_data_o(odata), .out_valid_o(ovalid),
    .out_ready_i(ready), .count_o(count),
    .overflow_o(ovf), .clr_ovf_i(clr_ovf)
  );

  systolic_drain #(
    .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
    .SHIFT(4), .FIFO_DEPTH(DEPTH)
  ) u_cnv (
    .clk(clk), .rstn(rstn), .acc_i(c_acc),
    .row_valid_i(c_valid), .stall_o(c_stall),
    .out_data_o(c_odata), .out_valid_o(c_ovalid),
    .out_ready_i(c_ready), .count_o(c_count),
    .overflow_o(c_ovf), .clr_ovf_i(c_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_row(input logic [63:0] b);
    logic [63:0] r;
    for (int j = 0; j < N; j++) r[j*OW +: OW] = OW'(b + 64'(j));
    return r;
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < N; k++) begin
      hv[k] = 1'b0; hb[k] = '0; chv[k] = 1'b0; chb[k] = '0;
    end
  endtask

  // Column j carries the row launched j cycles earlier.
  task automatic drive(
    input bit          lv,
    input logic [63:0] b,
    input bit          cv,
    input logic [63:0] cb
  );
    for (int k = N - 1; k > 0; k--) begin
      hv[k] = hv[k-1]; hb[k] = hb[k-1];
      chv[k] = chv[k-1]; chb[k] = chb[k-1];
    end
    hv[0] = lv; hb[0] = b; chv[0] = cv; chb[0] = cb;
    row_valid = lv;
    c_valid   = cv;
    for (int j = 0; j < N; j++) begin
      acc[j*AW +: AW]   = hv[j] ? hb[j] + 64'(j) : '0;
      c_acc[j*AW +: AW] = chv[j] ? chb[j] : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [63:0] cv [3];
    logic [63:0] exp_big;
    n_run = 0; n_fail = 0;
    rstn = 1'b0; ready = 1'b0; c_ready = 1'b0;
    clr_ovf = 1'b0; c_clr = 1'b0;
    row_valid = 1'b0; c_valid = 1'b0;
    acc = '0; c_acc = '0;
    clear_hist();
    idle(); idle();
    check("rst_valid", 64'(ovalid), 64'd0);
    check("rst_data",  64'(odata),  64'd0);
    check("rst_count", 64'(count),  64'd0);
    check("rst_stall", 64'(stall),  64'd0);
    check("rst_ovf",   64'(ovf),    64'd0);
    rstn = 1'b1;
    idle(); idle();

    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 64'd100, 1'b0, '0);
      if (i == 3) begin
        check("dsk_count", 64'(count), 64'd1);
        check("dsk_early", 64'(ovalid), 64'd0);
      end
      if (i == 4) begin
        check("dsk_valid", 64'(ovalid), 64'd1);
        check("dsk_row", 64'(odata), exp_row(64'd100));
      end
    end
    ready = 1'b1;
    idle();
    ready = 1'b0;
    check("dsk_pop_cnt", 64'(count), 64'd0);
    check("dsk_pop_vld", 64'(ovalid), 64'd0);

    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(i < 3, 64'(10 * (i + 1)), 1'b0, '0);
      if (i >= 4 && i <= 6) begin
        check("b2b_valid", 64'(ovalid), 64'd1);
        check("b2b_row", 64'(odata), exp_row(64'(10 * (i - 3))));
      end
      if (i == 7) check("b2b_end", 64'(ovalid), 64'd0);
    end
    ready = 1'b0;

    for (int i = 0; i < 19; i++) begin
      clr_ovf = (i >= 12 && i <= 14);
      ready   = (i == 18);
      drive((i <= 8) || (i == 10) || (i == 15),
            (i == 15) ? 64'd1100 : 64'(1000 + 10 * i), 1'b0, '0);
      case (i)
        4:  check("bp_head", 64'(odata), exp_row(64'd1000));
        5:  begin
              check("bp_cnt3", 64'(count), 64'd3);
              check("bp_stall0", 64'(stall), 64'd0);
            end
        6:  begin
              check("bp_cnt4", 64'(count), 64'd4);
              check("bp_stall1", 64'(stall), 64'd1);
            end
        10: begin
              check("bp_full", 64'(count), 64'd8);
              check("bp_noovf", 64'(ovf), 64'd0);
            end
        11: begin
              check("bp_drop_ovf", 64'(ovf), 64'd1);
              check("bp_drop_cnt", 64'(count), 64'd8);
            end
        12: check("ovf_clr", 64'(ovf), 64'd0);
        13: check("ovf_clr_drop", 64'(ovf), 64'd1);
        14: check("ovf_clr2", 64'(ovf), 64'd0);
        18: begin
              check("pwf_cnt", 64'(count), 64'd8);
              check("pwf_ovf", 64'(ovf), 64'd0);
              check("pwf_head", 64'(odata), exp_row(64'd1010));
            end
        default: ;
      endcase
    end
    clr_ovf = 1'b0;

    e = '{64'd1020, 64'd1030, 64'd1040, 64'd1050,
          64'd1060, 64'd1070, 64'd1100};
    ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      idle();
      check($sformatf("drain%0d", k), 64'(odata), exp_row(e[k]));
    end
    idle();
    ready = 1'b0;
    check("drain_cnt", 64'(count), 64'd0);
    check("drain_vld", 64'(ovalid), 64'd0);
    check("drain_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 6; i++) drive(i < 5, 64'(2000 + 10 * i), 1'b0, '0);
    check("prerst_cnt", 64'(count), 64'd3);
    rstn = 1'b0;
    #1;
    check("mrst_valid", 64'(ovalid), 64'd0);
    check("mrst_data",  64'(odata),  64'd0);
    check("mrst_count", 64'(count),  64'd0);
    check("mrst_stall", 64'(stall),  64'd0);
    check("mrst_ovf",   64'(ovf),    64'd0);
    clear_hist();
    idle(); idle();
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, 64'd500, 1'b0, '0);
      if (i == 2) check("post_cnt0", 64'(count), 64'd0);
      if (i == 3) check("post_cnt1", 64'(count), 64'd1);
      if (i == 4) begin
        check("post_valid", 64'(ovalid), 64'd1);
        check("post_row", 64'(odata), exp_row(64'd500));
      end
      if (i == 6) check("post_alone", 64'(count), 64'd1);
    end

    cv[0] = 64'h12345;
    cv[1] = 64'hFFFF_FFFF_FFFF_FFEF;
    cv[2] = 64'd1 << 40;
`ifdef SYSTOLIC_DRAIN_SAT_EN
    exp_big = {4{16'h7FFF}};
`else
    exp_big = 64'd0;
`endif
    for (int i = 0; i < 8; i++) drive(1'b0, '0, i < 3, (i < 3) ? cv[i] : '0);
    check("cnv_cnt", 64'(c_count), 64'd3);
    check("cnv_vld", 64'(c_ovalid), 64'd1);
    check("cnv_pos", 64'(c_odata), {4{16'h1234}});
    c_ready = 1'b1;
    idle();
    check("cnv_neg", 64'(c_odata), {4{16'hFFFE}});
    idle();
    check("cnv_big", 64'(c_odata), exp_big);
    c_ready = 1'b0;
    check("cnv_ovf", 64'(c_ovf), 64'd0);
    check("cnv_stall", 64'(c_stall), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
